// File: rtl/anc_pkg.sv
// anc_pkg: shared state/phase encodings and the circular-offset helper
// used by the FxLMS frame sequencer.
package anc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILT,
        S_FILT_DRN,
        S_SFILT,
        S_SFILT_DRN,
        S_LMS,
        S_DONE
    } state_e;

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_FILT  = 2'd1;
    localparam logic [1:0] PH_SFILT = 2'd2;
    localparam logic [1:0] PH_LMS   = 2'd3;

    // (ptr - off) mod taps; taps is a power of two so a mask is enough
    function automatic logic [31:0] circ_off(input logic [31:0] ptr, input logic [31:0] off,
                                             input int unsigned taps);
        return (ptr - off) & (taps - 1);
    endfunction

endpackage

// File: rtl/anc_tap_ctr.sv
// anc_tap_ctr: tap counter with optional LMS_CYC prescaler, per-tap step strobe,
// terminal count on the last cycle of the last tap, and synchronous clear.
module anc_tap_ctr #(
    parameter int TAPS    = 128,
    parameter int AW      = $clog2(TAPS),
    parameter int LMS_CYC = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic          slow,
    output logic [AW-1:0] tap,
    output logic [AW-1:0] tap_nxt,
    output logic          step,
    output logic          tc
);

    localparam int PW = LMS_CYC > 1 ? $clog2(LMS_CYC) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [AW-1:0] tap_q, tap_d;

    always_comb begin
        step  = !slow || pre_q == PW'(LMS_CYC - 1);
        tc    = step && tap_q == AW'(TAPS - 1);
        pre_d = clr ? '0 : !en ? pre_q : step ? '0 : pre_q + 1'b1;
        tap_d = clr ? '0 : (en && step) ? tap_q + 1'b1 : tap_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            tap_q <= '0;
        end else begin
            pre_q <= pre_d;
            tap_q <= tap_d;
        end
    end

    assign tap     = tap_q;
    assign tap_nxt = tap_d;

endmodule

// File: rtl/anc_frame_seq.sv
// anc_frame_seq: per-sample FxLMS sequencer; walks each channel through W*x, S*x
// and LMS update, generating RAM addresses, MAC control and the anti-noise output.
module anc_frame_seq
    import anc_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int TAPS    = 128,
    parameter int AW      = $clog2(TAPS),
    parameter int NCH     = 2,
    parameter int CW      = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int LMS_CYC = 3,
    parameter int MAC_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_valid,
    input  logic                     adapt_en,
    input  logic signed [DATA_W-1:0] mac_out,
    output logic                     mac_clr,
    output logic                     mac_en,
    output logic [1:0]               phase,
    output logic [CW-1:0]            ch,
    output logic [AW-1:0]            tap_idx,
    output logic [CW+AW-1:0]         wz_addr,
    output logic [CW+AW-1:0]         xn_addr,
    output logic [CW+AW-1:0]         sn_addr,
    output logic                     sn_wren,
    output logic                     wz_wren,
    output logic [AW-1:0]            sample_ptr,
    output logic signed [DATA_W-1:0] yn,
    output logic                     yn_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int DW = MAC_LAT > 1 ? $clog2(MAC_LAT) : 1;

    state_e                     state_q, state_d;
    logic [CW-1:0]              ch_q, ch_d;
    logic [AW-1:0]              ptr_q, ptr_d, tap_nxt;
    logic [DW-1:0]              dcnt_q, dcnt_d;
    logic signed [DATA_W-1:0]   yn_q, yn_d;
    logic                       ovr_q, ovr_d;
    logic [CW+AW-1:0]           wz_addr_q, wz_addr_d, x_addr_q, x_addr_d;
    logic                       t_clr, t_en, t_slow, t_step, t_tc, drn_last;

    anc_tap_ctr #(.TAPS(TAPS), .AW(AW), .LMS_CYC(LMS_CYC)) u_tap (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (t_clr),
        .en      (t_en),
        .slow    (t_slow),
        .tap     (tap_idx),
        .tap_nxt (tap_nxt),
        .step    (t_step),
        .tc      (t_tc)
    );

    assign drn_last = dcnt_q == DW'(MAC_LAT - 1);

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        ptr_d    = ptr_q;
        dcnt_d   = '0;
        yn_d     = yn_q;
        ovr_d    = ovr_q | (sample_valid & (state_q != S_IDLE));
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        yn_valid = 1'b0;
        sn_wren  = 1'b0;
        wz_wren  = 1'b0;
        t_clr    = 1'b0;
        t_en     = 1'b0;
        t_slow   = 1'b0;
        case (state_q)
            S_IDLE: if (sample_valid) begin
                state_d = S_FILT;
                ch_d    = '0;
                mac_clr = 1'b1;
                t_clr   = 1'b1;
            end
            S_FILT, S_SFILT: begin
                mac_en = 1'b1;
                t_en   = 1'b1;
                if (t_tc) state_d = (state_q == S_FILT) ? S_FILT_DRN : S_SFILT_DRN;
            end
            S_FILT_DRN: begin
                dcnt_d = dcnt_q + 1'b1;
                if (drn_last) begin
                    dcnt_d   = '0;
                    yn_d     = mac_out;
                    yn_valid = 1'b1;
                    mac_clr  = 1'b1;
                    state_d  = S_SFILT;
                end
            end
            S_SFILT_DRN: begin
                dcnt_d = dcnt_q + 1'b1;
                if (drn_last) begin
                    dcnt_d  = '0;
                    sn_wren = 1'b1;
                    state_d = adapt_en ? S_LMS : S_DONE;
                end
            end
            S_LMS: begin
                t_en    = 1'b1;
                t_slow  = 1'b1;
                wz_wren = t_step;
                if (t_tc) state_d = S_DONE;
            end
            S_DONE: begin
                if (ch_q != CW'(NCH - 1)) begin
                    ch_d    = ch_q + 1'b1;
                    t_clr   = 1'b1;
                    mac_clr = 1'b1;
                    state_d = S_FILT;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    ch_d    = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // addresses are registered from next-state values so they line up with tap_idx
    assign wz_addr_d = {ch_d, tap_nxt};
    assign x_addr_d  = {ch_d, AW'(circ_off(32'(ptr_d), 32'(tap_nxt), TAPS))};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            ptr_q     <= '0;
            dcnt_q    <= '0;
            yn_q      <= '0;
            ovr_q     <= 1'b0;
            wz_addr_q <= '0;
            x_addr_q  <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            ptr_q     <= ptr_d;
            dcnt_q    <= dcnt_d;
            yn_q      <= yn_d;
            ovr_q     <= ovr_d;
            wz_addr_q <= wz_addr_d;
            x_addr_q  <= x_addr_d;
        end
    end

    assign phase      = (state_q == S_FILT || state_q == S_FILT_DRN)   ? PH_FILT  :
                        (state_q == S_SFILT || state_q == S_SFILT_DRN) ? PH_SFILT :
                        (state_q == S_LMS)                             ? PH_LMS   : PH_IDLE;
    assign busy       = state_q != S_IDLE;
    assign ch         = ch_q;
    assign sample_ptr = ptr_q;
    assign yn         = yn_q;
    assign overrun    = ovr_q;
    assign wz_addr    = wz_addr_q;
    assign xn_addr    = x_addr_q;
    assign sn_addr    = x_addr_q;

endmodule

// File: doc/anc_frame_seq.md
# anc_frame_seq

Multi-channel, parametrised sequencer for the FxLMS active-noise-control datapath. On each audio sample it drives, per channel, three phases: control-filter convolution (W·x), secondary-path filtering (S·x), and the LMS weight update. It generates all coefficient and delay-line RAM addresses with circular wrap, controls the shared MAC, latches the anti-noise output, and advances the sample pointer. It sits between the audio receive interface and the W/S/X RAMs plus MAC/LMS datapath.

## Interface

Parameters:
- DATA_W, 24: width of MAC result and yn.
- TAPS, 128: filter length; must be a power of two, at least 4.
- AW, $clog2(TAPS): tap/offset address width.
- NCH, 2: channel count, at least 1.
- CW, max(1,$clog2(NCH)): channel index width.
- LMS_CYC, 3: cycles per tap in the LMS phase, at least 1.
- MAC_LAT, 2: MAC pipeline latency in cycles, at least 1.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- sample_valid, in, 1: one-cycle pulse; new xn written at sample_ptr for all channels.
- adapt_en, in, 1: when 0, the LMS phase is skipped (frozen weights).
- mac_out, in, signed DATA_W: MAC accumulator result.
- mac_clr, out, 1: clears the accumulator.
- mac_en, out, 1: accumulate the current product.
- phase, out, 2: 0 idle, 1 FILT, 2 SFILT, 3 LMS.
- ch, out, CW: active channel.
- tap_idx, out, AW: current tap.
- wz_addr, out, CW+AW: {ch, tap_idx}.
- xn_addr, out, CW+AW: {ch, (sample_ptr - tap_idx) mod TAPS}.
- sn_addr, out, CW+AW: {ch, (sample_ptr - tap_idx) mod TAPS}.
- sn_wren, out, 1: writes filtered reference at {ch, sample_ptr}.
- wz_wren, out, 1: LMS weight write strobe.
- sample_ptr, out, AW: circular write pointer.
- yn, out, signed DATA_W: per-channel anti-noise sample.
- yn_valid, out, 1: one-cycle pulse when yn updates.
- busy, out, 1: frame in progress.
- overrun, out, 1: sticky flag, cleared only by reset.

## Operation

- States: IDLE, FILT, FILT_DRN, SFILT, SFILT_DRN, LMS, DONE.
- IDLE: sample_valid=1 → FILT, ch=0, tap_idx=0, mac_clr=1 for that cycle.
- FILT: mac_en=1 and tap_idx increments each cycle; after tap TAPS-1 → FILT_DRN.
- FILT_DRN: lasts MAC_LAT cycles. On the last cycle: yn<=mac_out, yn_valid=1, mac_clr=1 → SFILT.
- SFILT: same as FILT, with xn/sn addressing for S·x, then SFILT_DRN.
- SFILT_DRN: lasts MAC_LAT cycles. The last cycle asserts sn_wren. Next state is LMS if adapt_en, else DONE. adapt_en is sampled at this cycle only.
- LMS: tap_idx advances every LMS_CYC cycles. wz_wren is asserted on the final cycle of each tap. After TAPS·LMS_CYC cycles → DONE.
- DONE: one cycle. If ch<NCH-1: ch++, tap_idx=0, mac_clr=1 → FILT. Else: sample_ptr++ (wraps TAPS-1→0), ch=0 → IDLE.
- All offsets use AW-bit unsigned arithmetic; wrap is natural modulo TAPS.
- sample_valid while busy sets overrun=1. That sample is dropped; the running frame is not disturbed.
- sample_valid in the DONE cycle of the last channel is also an overrun.

## Timing

- Reset values: state IDLE; all strobes 0; ch, tap_idx, sample_ptr, yn all 0; busy 0; overrun 0; phase 0.
- busy is 1 from the cycle after sample_valid through DONE of the last channel inclusive.
- Cycles per channel: 2·(TAPS+MAC_LAT) + TAPS·LMS_CYC + 1. Without adaptation: 2·(TAPS+MAC_LAT) + 1.
- Addresses are registered, valid in the same cycle as phase/tap_idx; RAM read latency is absorbed in MAC_LAT.
- yn first updates 1 + TAPS + MAC_LAT − 1 cycles after the sample_valid cycle, i.e. in the last FILT_DRN cycle.
- Reset mid-frame returns immediately to IDLE with reset values. The pointer is lost and no partial sn/wz write occurs after reset.

## Structure

- Shared package anc_pkg holds:
  - the state enum;
  - phase encodings PH_IDLE/PH_FILT/PH_SFILT/PH_LMS;
  - a function for circular offset.
- One sub-module, anc_tap_ctr: the tap counter with LMS_CYC prescaler, terminal-count output and synchronous clear. It is reused by all three phases.

## Test plan

- Params TAPS=8, NCH=1, LMS_CYC=3, MAC_LAT=2, adapt_en=1; pulse sample_valid at cycle 0 → busy cycles 1–45, yn_valid at cycle 10, sn_wren at cycle 20, 8 wz_wren pulses 3 cycles apart, sample_ptr 0→1.
- adapt_en=0 → frame length 21 cycles, no wz_wren.
- NCH=2, mac_out forced to 0x000123 then 0x000456 → two yn_valid pulses. yn=0x000123 with ch=0, then 0x000456 with ch=1; wz_addr MSB follows ch.
- sample_ptr=2 with FILT taps 0..7 → xn_addr offsets 2,1,0,7,6,5,4,3.
- sample_valid at cycle 5 mid-frame → overrun=1 and stays 1; frame completes at the normal cycle.
- rst_n low at cycle 30 for 1 cycle → all outputs return to reset values immediately; a new sample_valid restarts at sample_ptr=0.
